// File: rtl/det_seq_ctrl.sv
// Run controller for a serial sequence detector: arms a run, gates the bitstream, counts matches.
// Optional irq/irq_clr ports are built when DET_SEQ_CTRL_IRQ_EN is defined.
module det_seq_ctrl #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned TO_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cfg_overlap_i,
    input  logic [CNT_W-1:0] cfg_target_i,
    input  logic [TO_W-1:0]  cfg_timeout_i,
    input  logic             ser_in_i,
    output logic             det_in_o,
    output logic             det_overlap_o,
    output logic             det_clr_o,
    input  logic             det_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] match_count_o
`ifdef DET_SEQ_CTRL_IRQ_EN
    ,
    output logic             irq_o,
    input  logic             irq_clr_i
`endif
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StRun   = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StTout  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic             clr_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [TO_W-1:0]  timer_inc;
    logic             match_hit;
    logic             to_hit;

    // Both counters saturate so a long run can never wrap into a false match or timeout.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TO_W'(1);
    assign match_hit = det_out_i && (tgt_q != '0) && (cnt_inc == tgt_q);
    assign to_hit    = (to_q != '0) && (timer_q == to_q - TO_W'(1));

    always_comb begin
        state_d = state_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle, StDone, StTout: begin
                    if (start_i) begin
                        ovl_d   = cfg_overlap_i;
                        tgt_d   = cfg_target_i;
                        to_d    = cfg_timeout_i;
                        state_d = StClear;
                    end
                end
                StClear: begin
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = StRun;
                end
                StRun: begin
                    timer_d = timer_inc;
                    if (det_out_i) begin
                        cnt_d = cnt_inc;
                    end
                    // A completing match outranks a timeout landing on the same cycle.
                    if (match_hit) begin
                        state_d = StDone;
                    end else if (to_hit) begin
                        state_d = StTout;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            to_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            clr_q   <= (state_d == StClear);
        end
    end

    assign det_in_o      = (state_q == StRun) & ser_in_i;
    assign det_overlap_o = ovl_q;
    assign det_clr_o     = clr_q;
    assign busy_o        = (state_q == StClear) || (state_q == StRun);
    assign done_o        = (state_q == StDone);
    assign timeout_o     = (state_q == StTout);
    assign match_count_o = cnt_q;

`ifdef DET_SEQ_CTRL_IRQ_EN
    logic irq_q, irq_d;
    logic enter_term;

    assign enter_term = ((state_d == StDone) && (state_q != StDone)) ||
                        ((state_d == StTout) && (state_q != StTout));

    always_comb begin
        irq_d = irq_q;
        if (enter_term) begin
            irq_d = 1'b1;
        end else if (irq_clr_i || abort_i || (state_d == StClear)) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Self-checking bench for det_seq_ctrl: directed run scenarios, then randomized traffic
// compared every cycle against a run-level behavioural model.
module tb_det_seq_ctrl;

    localparam int CNT_W = 8;
    localparam int TO_W  = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i, abort_i, cfg_overlap_i, ser_in_i, det_out_i;
    logic [CNT_W-1:0] cfg_target_i;
    logic [TO_W-1:0]  cfg_timeout_i;
    logic             det_in_o, det_overlap_o, det_clr_o, busy_o, done_o, timeout_o;
    logic [CNT_W-1:0] match_count_o;
    logic             irq_o, irq_clr_i;

    always #5 clk = ~clk;

    det_seq_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .cfg_overlap_i (cfg_overlap_i),
        .cfg_target_i  (cfg_target_i),
        .cfg_timeout_i (cfg_timeout_i),
        .ser_in_i      (ser_in_i),
        .det_in_o      (det_in_o),
        .det_overlap_o (det_overlap_o),
        .det_clr_o     (det_clr_o),
        .det_out_i     (det_out_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .match_count_o (match_count_o)
`ifdef DET_SEQ_CTRL_IRQ_EN
        ,
        .irq_o         (irq_o),
        .irq_clr_i     (irq_clr_i)
`endif
    );

`ifndef DET_SEQ_CTRL_IRQ_EN
    assign irq_o = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Run-level model: which phase the run is in, how many RUN cycles elapsed, matches seen.
    bit m_clearing, m_running, m_done, m_tout, m_ovl, m_irq;
    int m_tgt, m_to, m_cnt, m_runcyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clearing = 0; m_running = 0; m_done = 0; m_tout = 0;
        m_ovl = 0; m_irq = 0; m_tgt = 0; m_to = 0; m_cnt = 0; m_runcyc = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit dout, input bit iclr);
        bit idle;
        bit entered;
        idle    = !(m_clearing || m_running || m_done || m_tout);
        entered = 0;
        if (ab) begin
            m_clearing = 0; m_running = 0; m_done = 0; m_tout = 0; m_irq = 0;
        end else if ((idle || m_done || m_tout) && st) begin
            m_ovl = cfg_overlap_i; m_tgt = int'(cfg_target_i); m_to = int'(cfg_timeout_i);
            m_clearing = 1; m_done = 0; m_tout = 0; m_irq = 0;
        end else if (m_clearing) begin
            m_clearing = 0; m_running = 1; m_cnt = 0; m_runcyc = 0;
        end else if (m_running) begin
            m_runcyc++;
            if (dout && m_cnt < 255) m_cnt++;
            if (m_tgt != 0 && dout && m_cnt == m_tgt) begin
                m_running = 0; m_done = 1; entered = 1;
            end else if (m_to != 0 && m_runcyc == m_to) begin
                m_running = 0; m_tout = 1; entered = 1;
            end
        end
        if (entered) m_irq = 1;
        else if (iclr) m_irq = 0;
    endtask

    task automatic compare_all();
        check("det_in", det_in_o, m_running & ser_in_i);
        check("det_overlap", det_overlap_o, m_ovl);
        check("det_clr", det_clr_o, m_clearing);
        check("busy", busy_o, m_clearing | m_running);
        check("done", done_o, m_done);
        check("timeout", timeout_o, m_tout);
        check("match_count", match_count_o, m_cnt);
`ifdef DET_SEQ_CTRL_IRQ_EN
        check("irq", irq_o, m_irq);
`endif
    endtask

    // Called at posedge+1; drives inputs, checks outputs, then advances one clock.
    task automatic cycle(input bit st, input bit ab, input bit dout, input bit ser,
                         input bit iclr = 0);
        start_i = st; abort_i = ab; det_out_i = dout; ser_in_i = ser; irq_clr_i = iclr;
        #1;
        compare_all();
        @(posedge clk);
        model_step(st, ab, dout, iclr);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic arm(input int tgt, input int to, input bit ov);
        cfg_target_i = CNT_W'(tgt); cfg_timeout_i = TO_W'(to); cfg_overlap_i = ov;
        cycle(1, 0, 0, 0);
    endtask

    initial begin
        bit sers[5];
        bit douts[5];
        start_i = 0; abort_i = 0; det_out_i = 0; ser_in_i = 0; irq_clr_i = 0;
        cfg_overlap_i = 0; cfg_target_i = '0; cfg_timeout_i = '0;
        do_reset();
        check("reset_busy", busy_o, 1'b0);
        check("reset_count", match_count_o, 0);

        // Scenario 1: overlap run, matches on bits 3 and 5 end the run at target 2.
        sers  = '{1, 0, 1, 0, 1};
        douts = '{0, 0, 1, 0, 1};
        arm(2, 0, 1);
        check("s1_clr_pulse", det_clr_o, 1'b1);
        cycle(0, 0, 0, 0);
        check("s1_clr_low", det_clr_o, 1'b0);
        for (int i = 0; i < 5; i++) cycle(0, 0, douts[i], sers[i]);
        check("s1_done", done_o, 1'b1);
        check("s1_count", match_count_o, 2);
        check("s1_ovl", det_overlap_o, 1'b1);

        // Scenario 2: non-overlap run sees one match, then abort keeps the count.
        douts = '{0, 0, 1, 0, 0};
        arm(2, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, douts[i], sers[i]);
        check("s2_busy", busy_o, 1'b1);
        check("s2_count", match_count_o, 1);
        cycle(0, 1, 0, 0);
        check("s2_idle", busy_o | done_o | timeout_o, 1'b0);
        check("s2_count_hold", match_count_o, 1);

        // Scenario 3: timeout of 8 fires after exactly 8 RUN cycles.
        arm(5, 8, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0);
        check("s3_not_yet", timeout_o, 1'b0);
        cycle(0, 0, 0, 0);
        check("s3_timeout", timeout_o, 1'b1);
        check("s3_count", match_count_o, 0);

        // Scenario 4: completing match on the timeout cycle wins.
        arm(1, 4, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 1);
        check("s4_done", done_o, 1'b1);
        check("s4_no_tout", timeout_o, 1'b0);
        check("s4_count", match_count_o, 1);

        // Scenario 5: starts in CLEAR/RUN are ignored; async reset clears outputs at once.
        arm(0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 1);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 1);
        check("s5_busy", busy_o, 1'b1);
        check("s5_count", match_count_o, 3);
        rst_i = 1'b1;
        #1;
        check("s5_rst_count", match_count_o, 0);
        check("s5_rst_busy", busy_o, 1'b0);
        check("s5_rst_ovl", det_overlap_o, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;

`ifdef DET_SEQ_CTRL_IRQ_EN
        // Scenario 6: irq set on DONE, cleared by irq_clr and by a re-arming start.
        arm(1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("s6_irq_set", irq_o, 1'b1);
        cycle(0, 0, 0, 0, 1);
        check("s6_irq_clr", irq_o, 1'b0);
        arm(1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("s6_irq_again", irq_o, 1'b1);
        arm(1, 0, 0);
        check("s6_rearm_irq", irq_o, 1'b0);
        check("s6_rearm_clr", det_clr_o, 1'b1);
        cycle(0, 0, 0, 0);
        check("s6_clr_once", det_clr_o, 1'b0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cfg_target_i  = CNT_W'($urandom_range(0, 4));
                cfg_timeout_i = TO_W'($urandom_range(0, 12));
                cfg_overlap_i = 1'($urandom_range(0, 1));
                cycle($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
